command_receiver: RTL

- Front end of the accelerator; opposite end of the UART link from the processing/transmit block.
- Decodes command bytes arriving from the UART receiver.
- Write commands: streams the following NBytes data bytes into BRAM A or BRAM B.
- Operation commands: issues the 4-bit result pulse to the processing block, then blocks new commands until that block reports done.

---
 rtl/accel_pkg.sv | 44 ++++
 rtl/command_receiver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator front end and processing block:
// command bytes, 4-bit result codes and the receiver state encoding.
package accel_pkg;

    localparam logic [7:0] CMD_WRITE_A  = 8'h01;
    localparam logic [7:0] CMD_WRITE_B  = 8'h02;
    localparam logic [7:0] CMD_READ_A   = 8'h03;
    localparam logic [7:0] CMD_READ_B   = 8'h04;
    localparam logic [7:0] CMD_SUM      = 8'h05;
    localparam logic [7:0] CMD_AVG      = 8'h06;
    localparam logic [7:0] CMD_EUC_DIST = 8'h07;
    localparam logic [7:0] CMD_MAN_DIST = 8'h08;

    // [3] valid, [2] vector(1)/scalar(0), [1:0] op
    localparam logic [3:0] RES_NONE     = 4'b0000;
    localparam logic [3:0] RES_READ_A   = 4'b1100;
    localparam logic [3:0] RES_READ_B   = 4'b1101;
    localparam logic [3:0] RES_SUM      = 4'b1110;
    localparam logic [3:0] RES_AVG      = 4'b1111;
    localparam logic [3:0] RES_EUC_DIST = 4'b1000;
    localparam logic [3:0] RES_MAN_DIST = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WAIT
    } rx_state_e;

    // Maps an operation command byte to its result code; RES_NONE otherwise.
    function automatic logic [3:0] cmd_result(input logic [7:0] cmd);
        logic [3:0] res;
        case (cmd)
            CMD_READ_A:   res = RES_READ_A;
            CMD_READ_B:   res = RES_READ_B;
            CMD_SUM:      res = RES_SUM;
            CMD_AVG:      res = RES_AVG;
            CMD_EUC_DIST: res = RES_EUC_DIST;
            CMD_MAN_DIST: res = RES_MAN_DIST;
            default:      res = RES_NONE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/command_receiver.sv
// UART command decoder: streams vectors into BRAM A/B and issues operation pulses.
// Define RX_TIMEOUT_EN to abort a stalled vector write after TIMEOUT_CYCLES idle cycles.
module command_receiver
    import accel_pkg::*;
#(
    parameter int unsigned NBytes         = 1024,
    parameter int unsigned AW             = $clog2(NBytes),
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    input  logic          proc_done,
    output logic          bram_we_a,
    output logic          bram_we_b,
    output logic [AW-1:0] bram_addr,
    output logic [7:0]    bram_data,
    output logic [3:0]    result,
    output logic          busy,
    output logic          write_done,
    output logic          error
);

    localparam logic [AW-1:0] LastAddr = AW'(NBytes - 1);

    if (NBytes < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("command_receiver: NBytes and TIMEOUT_CYCLES must both be at least 2");
    end

    rx_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          target_b_q, target_b_d;
    logic          we_a_q, we_a_d;
    logic          we_b_q, we_b_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    result_q, result_d;
    logic          busy_q, busy_d;
    logic          write_done_q, write_done_d;

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          error_q, error_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_b_d   = target_b_q;
        we_a_d       = 1'b0;
        we_b_d       = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        result_d     = RES_NONE;
        write_done_d = 1'b0;
`ifdef RX_TIMEOUT_EN
        tmo_d        = '0;
        error_d      = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    if (rx_data == CMD_WRITE_A || rx_data == CMD_WRITE_B) begin
                        state_d    = RECV;
                        cnt_d      = '0;
                        target_b_d = (rx_data == CMD_WRITE_B);
                    end else if (cmd_result(rx_data) != RES_NONE) begin
                        result_d = cmd_result(rx_data);
                        state_d  = WAIT;
                    end
                end
            end
            RECV: begin
                // Payload bytes are stored verbatim, never decoded.
                if (rx_ready) begin
                    data_d = rx_data;
                    addr_d = cnt_q;
                    we_a_d = ~target_b_q;
                    we_b_d = target_b_q;
                    if (cnt_q == LastAddr) begin
                        cnt_d        = '0;
                        write_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef RX_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    error_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            WAIT: begin
                // A byte arriving alongside proc_done is dropped as well.
                if (proc_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            target_b_q   <= 1'b0;
            we_a_q       <= 1'b0;
            we_b_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            result_q     <= RES_NONE;
            busy_q       <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_b_q   <= target_b_d;
            we_a_q       <= we_a_d;
            we_b_q       <= we_b_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            write_done_q <= write_done_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bram_we_a  = we_a_q;
    assign bram_we_b  = we_b_q;
    assign bram_addr  = addr_q;
    assign bram_data  = data_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign write_done = write_done_q;

endmodule
